// File: rtl/tpu_cfg_pkg.sv
// Shared register map, bit positions and FSM encoding for the TPU configuration controller.
package tpu_cfg_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_ENABLES = 8'h04;
  localparam logic [7:0] ADDR_STATUS  = 8'h08;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h0C;
  localparam logic [7:0] ADDR_CYCLES  = 8'h10;
  localparam logic [7:0] ADDR_RUNS    = 8'h14;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_AUTO_CLR_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic ctrl;
    logic enables;
    logic status;
    logic irq_en;
  } cfg_wr_t;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] enables;
    logic [31:0] status;
    logic [31:0] irq_en;
    logic [31:0] cycles;
    logic [31:0] runs;
  } cfg_rd_t;

endpackage

// File: rtl/tpu_cfg_apb_if.sv
// APB slave front end: address decode into write strobes and the combinational read mux.
module tpu_cfg_apb_if
  import tpu_cfg_pkg::*;
(
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  cfg_rd_t     rd,
  output cfg_wr_t     wr,
  output logic [31:0] prdata,
  output logic        pready
);

  logic        wr_en;
  logic [31:0] rd_word;

  assign wr_en  = psel & penable & pwrite;
  assign pready = 1'b1;

  always_comb begin
    wr      = '0;
    rd_word = '0;
    case (paddr)
      ADDR_CTRL: begin
        wr.ctrl = wr_en;
        rd_word = rd.ctrl;
      end
      ADDR_ENABLES: begin
        wr.enables = wr_en;
        rd_word    = rd.enables;
      end
      ADDR_STATUS: begin
        wr.status = wr_en;
        rd_word   = rd.status;
      end
      ADDR_IRQ_EN: begin
        wr.irq_en = wr_en;
        rd_word   = rd.irq_en;
      end
      ADDR_CYCLES: rd_word = rd.cycles;
      ADDR_RUNS:   rd_word = rd.runs;
      default:     rd_word = '0;
    endcase
  end

  assign prdata = psel ? rd_word : 32'h0;

endmodule

// File: rtl/tpu_cfg_ctrl.sv
// TPU run controller: configuration registers, start/done handshake FSM, cycle and run counters.
module tpu_cfg_ctrl
  import tpu_cfg_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        start_tpu,
  input  logic        done_tpu,
  output logic        enable_matmul,
  output logic        enable_norm,
  output logic        enable_pool,
  output logic        enable_activation,
  output logic        irq
);

  cfg_wr_t wr;
  cfg_rd_t rd;

  logic [1:0]       state_q,   state_d;
  logic             start_q,   start_d;
  logic             auto_clr_q, auto_clr_d;
  logic [3:0]       enables_q, enables_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic             irq_en_q,  irq_en_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] cycles_q,  cycles_d;
  logic [7:0]       runs_q,    runs_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_wdata;

  assign unused_wdata = ^pwdata[31:4];

  tpu_cfg_apb_if u_apb_if (
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .rd      (rd),
    .wr      (wr),
    .prdata  (prdata),
    .pready  (pready)
  );

  always_comb begin
    rd                            = '0;
    rd.ctrl[CTRL_START_BIT]       = start_q;
    rd.ctrl[CTRL_AUTO_CLR_BIT]    = auto_clr_q;
    rd.enables[3:0]               = enables_q;
    rd.status[STAT_BUSY_BIT]      = (state_q != ST_IDLE);
    rd.status[STAT_DONE_BIT]      = done_q;
    rd.status[STAT_ERR_BIT]       = err_q;
    rd.irq_en[0]                  = irq_en_q;
    rd.cycles                     = 32'(cycles_q);
    rd.runs[7:0]                  = runs_q;
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Hardware flag sets come after the W1C clears so a same-cycle set wins.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    auto_clr_d = auto_clr_q;
    enables_d  = enables_q;
    done_d     = done_q;
    err_d      = err_q;
    irq_en_d   = irq_en_q;
    cnt_d      = cnt_q;
    cycles_d   = cycles_q;
    runs_d     = runs_q;

    if (wr.ctrl) begin
      auto_clr_d = pwdata[CTRL_AUTO_CLR_BIT];
      if (!pwdata[CTRL_START_BIT]) start_d = 1'b0;
    end
    if (wr.enables && (state_q == ST_IDLE)) enables_d = pwdata[3:0];
    if (wr.irq_en) irq_en_d = pwdata[0];
    if (wr.status) begin
      if (pwdata[STAT_DONE_BIT]) done_d = 1'b0;
      if (pwdata[STAT_ERR_BIT])  err_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr.ctrl && pwdata[CTRL_START_BIT]) begin
          if (enables_q[0]) begin
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (done_tpu) begin
          cycles_d = cnt_inc;
          done_d   = 1'b1;
          runs_d   = runs_q + 8'd1;
          if (auto_clr_q) start_d = 1'b0;
          state_d  = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!start_q && !done_tpu) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      auto_clr_q <= 1'b0;
      enables_q  <= 4'b0001;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      cnt_q      <= '0;
      cycles_q   <= '0;
      runs_q     <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      auto_clr_q <= auto_clr_d;
      enables_q  <= enables_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_en_q   <= irq_en_d;
      cnt_q      <= cnt_d;
      cycles_q   <= cycles_d;
      runs_q     <= runs_d;
    end
  end

  assign start_tpu         = start_q;
  assign enable_matmul     = enables_q[0];
  assign enable_norm       = enables_q[1];
  assign enable_pool       = enables_q[2];
  assign enable_activation = enables_q[3];
  assign irq               = irq_en_q & (done_q | err_q);

endmodule

// File: tb/tb_tpu_cfg_ctrl.sv
// Self-checking bench: default-width and 4-bit-counter instances driven in lockstep.
module tb_tpu_cfg_ctrl;
  import tpu_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        done_tpu = 1'b0;

  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, start_a, start_b, irq_a, irq_b;
  logic        em_a, en_a, ep_a, ea_a, em_b, en_b, ep_b, ea_b;

  tpu_cfg_ctrl dut_a (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .start_tpu(start_a), .done_tpu(done_tpu), .enable_matmul(em_a),
    .enable_norm(en_a), .enable_pool(ep_a), .enable_activation(ea_a), .irq(irq_a)
  );

  tpu_cfg_ctrl #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .start_tpu(start_b), .done_tpu(done_tpu), .enable_matmul(em_b),
    .enable_norm(en_b), .enable_pool(ep_b), .enable_activation(ea_b), .irq(irq_b)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int runs_exp = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_raw(input logic [7:0] addr, input bit on_b, output logic [31:0] data);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
    #1;
    data = on_b ? prdata_b : prdata_a;
    psel = 1'b0;
  endtask

  task automatic rd_exp(input string tag, input logic [7:0] addr, input logic [31:0] exp,
                        input bit on_b = 1'b0);
    sb_t         e;
    logic [31:0] obs;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    rd_raw(addr, on_b, obs);
    e = sb_q.pop_front();
    chk(e.tag, obs, e.exp);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    rd_raw(ADDR_STATUS, 1'b0, st);
    for (int i = 0; i < 20 && st[STAT_BUSY_BIT]; i++) begin
      @(negedge clk);
      rd_raw(ADDR_STATUS, 1'b0, st);
    end
    chk(tag, {31'b0, st[STAT_BUSY_BIT]}, 32'h0);
  endtask

  task automatic do_run(input int n, input bit auto_clr);
    apb_wr(ADDR_CTRL, {30'b0, auto_clr, 1'b1});
    repeat (n - 1) @(negedge clk);
    done_tpu = 1'b1;
    @(negedge clk);
    if (!auto_clr) apb_wr(ADDR_CTRL, 32'h0);
    done_tpu = 1'b0;
    runs_exp = (runs_exp + 1) % 256;
    wait_idle("run_idle");
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_start", {31'b0, start_a}, 32'h0);
    chk("rst_irq", {31'b0, irq_a}, 32'h0);
    chk("rst_pready", {31'b0, pready_a}, 32'h1);
    chk("rst_en_out", {28'b0, ea_a, ep_a, en_a, em_a}, 32'h1);
    rd_exp("rst_ctrl", ADDR_CTRL, 32'h0);
    rd_exp("rst_enables", ADDR_ENABLES, 32'h1);
    rd_exp("rst_status", ADDR_STATUS, 32'h0);
    rd_exp("rst_irq_en", ADDR_IRQ_EN, 32'h0);
    rd_exp("rst_cycles", ADDR_CYCLES, 32'h0);
    rd_exp("rst_runs", ADDR_RUNS, 32'h0);
    rd_exp("unmapped_rd", 8'h18, 32'h0);

    // basic auto-clear run of 10 cycles
    apb_wr(ADDR_ENABLES, 32'h3);
    chk("en_out_3", {28'b0, ea_a, ep_a, en_a, em_a}, 32'h3);
    apb_wr(ADDR_CTRL, 32'h3);
    chk("start_set", {31'b0, start_a}, 32'h1);
    rd_exp("ctrl_run", ADDR_CTRL, 32'h3);
    rd_exp("status_busy", ADDR_STATUS, 32'h1);
    repeat (9) @(negedge clk);
    done_tpu = 1'b1;
    @(negedge clk);
    chk("autoclr_start", {31'b0, start_a}, 32'h0);
    rd_exp("cycles_10", ADDR_CYCLES, 32'd10);
    rd_exp("cycles_10_w4", ADDR_CYCLES, 32'd10, 1'b1);
    rd_exp("status_drop", ADDR_STATUS, 32'h3);
    rd_exp("runs_1", ADDR_RUNS, 32'd1);
    rd_exp("ctrl_autoclr", ADDR_CTRL, 32'h2);
    done_tpu = 1'b0;
    runs_exp = 1;
    @(negedge clk);
    rd_exp("status_idle", ADDR_STATUS, 32'h2);

    // start refused with matmul disabled, error interrupt
    apb_wr(ADDR_STATUS, 32'h2);
    rd_exp("done_w1c", ADDR_STATUS, 32'h0);
    apb_wr(ADDR_ENABLES, 32'h0);
    rd_exp("enables_0", ADDR_ENABLES, 32'h0);
    apb_wr(ADDR_CTRL, 32'h1);
    chk("no_start", {31'b0, start_a}, 32'h0);
    rd_exp("status_err", ADDR_STATUS, 32'h4);
    rd_exp("ctrl_err", ADDR_CTRL, 32'h0);
    chk("irq_masked", {31'b0, irq_a}, 32'h0);
    apb_wr(ADDR_IRQ_EN, 32'h1);
    chk("irq_err", {31'b0, irq_a}, 32'h1);
    apb_wr(ADDR_STATUS, 32'h4);
    chk("irq_clr", {31'b0, irq_a}, 32'h0);
    rd_exp("status_clr", ADDR_STATUS, 32'h0);

    // no auto-clear: start held until software drops it
    apb_wr(ADDR_ENABLES, 32'h1);
    apb_wr(ADDR_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    done_tpu = 1'b1;
    @(negedge clk);
    rd_exp("status_done", ADDR_STATUS, 32'h3);
    chk("irq_done", {31'b0, irq_a}, 32'h1);
    repeat (3) @(negedge clk);
    chk("start_held", {31'b0, start_a}, 32'h1);
    apb_wr(ADDR_CTRL, 32'h0);
    chk("start_sw_clr", {31'b0, start_a}, 32'h0);
    apb_wr(ADDR_CTRL, 32'h1);
    chk("drop_start_ign", {31'b0, start_a}, 32'h0);
    done_tpu = 1'b0;
    runs_exp = 2;
    repeat (2) @(negedge clk);
    rd_exp("drop_to_idle", ADDR_STATUS, 32'h2);
    rd_exp("cycles_5", ADDR_CYCLES, 32'd5);
    rd_exp("runs_2", ADDR_RUNS, 32'd2);
    apb_wr(ADDR_STATUS, 32'h2);
    chk("irq_off", {31'b0, irq_a}, 32'h0);

    // DONE W1C on the same edge done_tpu first rises
    apb_wr(ADDR_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = ADDR_STATUS; pwdata = 32'h2;
    @(negedge clk);
    penable = 1'b1;
    done_tpu = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd_exp("set_wins", ADDR_STATUS, 32'h3);
    apb_wr(ADDR_CTRL, 32'h0);
    done_tpu = 1'b0;
    runs_exp = 3;
    wait_idle("idle_after_w1c");
    rd_exp("runs_3", ADDR_RUNS, 32'd3);
    apb_wr(ADDR_STATUS, 32'h6);

    // done_tpu ignored in IDLE
    done_tpu = 1'b1;
    repeat (3) @(negedge clk);
    done_tpu = 1'b0;
    @(negedge clk);
    rd_exp("idle_done_ign", ADDR_STATUS, 32'h0);
    rd_exp("idle_runs", ADDR_RUNS, 32'd3);

    // ENABLES locked while busy, then reset mid-run
    apb_wr(ADDR_CTRL, 32'h1);
    apb_wr(ADDR_ENABLES, 32'hF);
    rd_exp("en_locked", ADDR_ENABLES, 32'h1);
    chk("en_out_locked", {28'b0, ea_a, ep_a, en_a, em_a}, 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    runs_exp = 0;
    chk("rst_mid_start", {31'b0, start_a}, 32'h0);
    rd_exp("rst_mid_en", ADDR_ENABLES, 32'h1);
    rd_exp("rst_mid_runs", ADDR_RUNS, 32'h0);
    rd_exp("rst_mid_status", ADDR_STATUS, 32'h0);
    rd_exp("rst_mid_irq_en", ADDR_IRQ_EN, 32'h0);

    // run counter wrap
    for (int i = 1; i <= 256; i++) begin
      do_run(2, 1'b1);
      if (i == 255) rd_exp("runs_255", ADDR_RUNS, 32'(runs_exp));
    end
    rd_exp("runs_wrap", ADDR_RUNS, 32'(runs_exp));
    rd_exp("runs_wrap_w4", ADDR_RUNS, 32'h0, 1'b1);
    rd_exp("cycles_2", ADDR_CYCLES, 32'd2);

    // counter saturation on the 4-bit instance
    do_run(20, 1'b1);
    rd_exp("cycles_20", ADDR_CYCLES, 32'd20);
    rd_exp("cycles_sat_w4", ADDR_CYCLES, 32'd15, 1'b1);
    do_run(14, 1'b0);
    rd_exp("cycles_14_w4", ADDR_CYCLES, 32'd14, 1'b1);
    rd_exp("runs_final", ADDR_RUNS, 32'(runs_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
